audio_pwm_mixer: RTL and testbench

Parametrised multi-channel audio output stage for the console top level. It sums N_CH unsigned channel samples from the sound generators (PSG tone and noise channels, later FM) under a per-channel enable mask. The sum drives the single-bit board audio pin as frame-locked PWM. It also generates the divided clock-enable strobe that paces the sound chips, so the top level no longer carries a hand-built divider.

---
 rtl/audio_pkg.sv | 32 +++
 rtl/audio_pwm_mixer_if.sv | 39 +++
 rtl/audio_ce_divider.sv | 30 +++
 rtl/audio_pwm_mixer.sv | 102 ++++++++++
 tb/tb_audio_pwm_mixer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio output path: the PSG clock-enable
// default divide ratio, a constant-safe clog2 helper and the channel sample
// array type used by the PSG, FM and mixer blocks.
package audio_pkg;

  // CLK100MHZ cycles per PSG clock-enable pulse at the console top level.
  localparam int DIV_PSG_DEFAULT = 26;

  // Default mixer geometry: four 8-bit unsigned channels.
  localparam int N_CH_DEFAULT     = 4;
  localparam int SAMPLE_W_DEFAULT = 8;

  // Ceiling log2, usable in parameter defaults; clog2(1) is 0 so a single
  // channel mixer needs no extra headroom bits.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // One unsigned channel sample and the packed array of all channels, in the
  // default geometry, as produced by the sound generators.
  typedef logic [SAMPLE_W_DEFAULT-1:0]         sample_t;
  typedef sample_t [N_CH_DEFAULT-1:0]          ch_sample_arr_t;

endpackage

// File: rtl/audio_pwm_mixer_if.sv
// Bundle between the sound generators and the audio output stage: channel
// samples and enables flow in, the PSG clock enable, frame marker, applied
// duty and the audio pin bit flow out.
// master: sound-generator side (drives samples, observes outputs)
// slave : audio_pwm_mixer side
interface audio_pwm_mixer_if
  import audio_pkg::*;
#(
  parameter int N_CH     = N_CH_DEFAULT,
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int PWM_W    = SAMPLE_W + clog2(N_CH)
);

  logic [N_CH-1:0][SAMPLE_W-1:0] ch_sample;
  logic [N_CH-1:0]               ch_en;
  logic                          psg_ce;
  logic                          frame_start;
  logic [PWM_W-1:0]              duty;
  logic                          AUD_PWM;

  modport master (
    output ch_sample,
    output ch_en,
    input  psg_ce,
    input  frame_start,
    input  duty,
    input  AUD_PWM
  );

  modport slave (
    input  ch_sample,
    input  ch_en,
    output psg_ce,
    output frame_start,
    output duty,
    output AUD_PWM
  );

endinterface

// File: rtl/audio_ce_divider.sv
// Free-running clock-enable generator: one registered single-cycle pulse
// every DIV clocks (DIV >= 2). The first pulse appears DIV cycles after
// reset is released. Reused for the PSG and future FM clock enables.
module audio_ce_divider
  import audio_pkg::*;
#(
  parameter int DIV = DIV_PSG_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic psg_ce
);

  localparam int              CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // Count 0..DIV-1 and pulse on the cycle after the counter reaches its top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      psg_ce  <= 1'b0;
    end else begin
      psg_ce  <= (div_cnt == LAST);
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audio_pwm_mixer.sv
// Multi-channel audio output stage: sums the enabled channel samples, loads
// the sum as the duty of the next PWM frame and drives the board audio pin.
// Also produces the PSG clock-enable strobe via audio_ce_divider.
// Optional feature: define AUDIO_SIGMA_DELTA_EN to replace the PWM
// comparator with a first-order sigma-delta modulator fed by the same duty.
module audio_pwm_mixer
  import audio_pkg::*;
#(
  parameter int N_CH     = N_CH_DEFAULT,
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int PWM_W    = SAMPLE_W + clog2(N_CH),
  parameter int DIV      = DIV_PSG_DEFAULT
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  audio_pwm_mixer_if.slave   bus
);

  // The PWM_W constraint (N_CH*(2^SAMPLE_W-1) < 2^PWM_W) keeps the sum from
  // wrapping and keeps duty strictly below a full frame.
  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  logic [PWM_W-1:0] mix_sum;
  logic [PWM_W-1:0] sum_r;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty;
  logic             frame_start;
  logic             aud_pwm;
  logic             psg_ce;
  logic             frame_end;

  audio_ce_divider #(
    .DIV (DIV)
  ) u_psg_div (
    .clk    (CLK100MHZ),
    .rst_n  (CPU_RESETN),
    .psg_ce (psg_ce)
  );

  assign frame_end = (pwm_cnt == CNT_MAX);

  // Add up every enabled channel, zero-extended to the duty width.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.ch_en[i]) begin
        mix_sum = mix_sum + PWM_W'(bus.ch_sample[i]);
      end
    end
  end

  // Register the mix, run the frame counter and latch duty only at the frame
  // boundary so mid-frame sample changes never disturb the running frame.
  // frame_start is registered from the last count, so it is high while
  // pwm_cnt is 0 except for the very first cycle after reset.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      sum_r       <= '0;
      pwm_cnt     <= '0;
      duty        <= '0;
      frame_start <= 1'b0;
    end else begin
      sum_r       <= mix_sum;
      pwm_cnt     <= pwm_cnt + 1'b1;
      frame_start <= frame_end;
      if (frame_end) begin
        duty <= sum_r;
      end
    end
  end

`ifdef AUDIO_SIGMA_DELTA_EN
  logic [PWM_W:0] acc;

  // First-order sigma-delta: accumulate duty modulo one frame, the carry out
  // of the accumulator is the output bit; density of ones equals duty/2^PWM_W.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      acc     <= '0;
      aud_pwm <= 1'b0;
    end else begin
      acc     <= {1'b0, acc[PWM_W-1:0]} + {1'b0, duty};
      aud_pwm <= acc[PWM_W];
    end
  end
`else
  // Plain PWM comparator: high for exactly duty cycles of every frame.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      aud_pwm <= 1'b0;
    end else begin
      aud_pwm <= (pwm_cnt < duty);
    end
  end
`endif

  assign bus.psg_ce      = psg_ce;
  assign bus.frame_start = frame_start;
  assign bus.duty        = duty;
  assign bus.AUD_PWM     = aud_pwm;

endmodule

// File: tb/tb_audio_pwm_mixer.sv
// Self-checking bench for audio_pwm_mixer in its default geometry.
// The reference model works from elapsed cycles since reset: frame number,
// position in frame and the mix captured at each frame boundary.
module tb_audio_pwm_mixer;
  import audio_pkg::*;

  localparam int N_CH     = 4;
  localparam int SAMPLE_W = 8;
  localparam int PWM_W    = 10;
  localparam int DIV      = 26;
  localparam int FRAME    = 1 << PWM_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  audio_pwm_mixer_if #(
    .N_CH     (N_CH),
    .SAMPLE_W (SAMPLE_W),
    .PWM_W    (PWM_W)
  ) bus ();

  audio_pwm_mixer #(
    .N_CH     (N_CH),
    .SAMPLE_W (SAMPLE_W),
    .PWM_W    (PWM_W),
    .DIV      (DIV)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus.slave)
  );

  ch_sample_arr_t samples;
  logic [N_CH-1:0] enables;

  assign bus.ch_sample = samples;
  assign bus.ch_en     = enables;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  int t_m    = 0;
  int sum_m  = 0;
  int duty_m = 0;
  int acc_m  = 0;
  bit aud_m  = 1'b0;
  bit fs_m   = 1'b0;
  bit ce_m   = 1'b0;

  int hi_cnt      = 0;
  int frame_duty  = 0;
  bit frame_valid = 1'b0;

  bit count_ce = 1'b0;
  int ce_count = 0;
  int first_ce = -1;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s t=%0d observed=%0d expected=%0d", tag, t_m, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int s0, input int s1, input int s2,
                                input int s3, input logic [N_CH-1:0] en);
    samples[0] = sample_t'(s0);
    samples[1] = sample_t'(s1);
    samples[2] = sample_t'(s2);
    samples[3] = sample_t'(s3);
    enables    = en;
  endtask

  task automatic step();
    int new_sum;
    @(posedge clk);
    if (!rst_n) begin
      t_m    = 0;
      sum_m  = 0;
      duty_m = 0;
      acc_m  = 0;
      aud_m  = 1'b0;
    end else begin
      new_sum = 0;
      for (int i = 0; i < N_CH; i++) begin
        if (enables[i]) new_sum += int'(samples[i]);
      end
`ifdef AUDIO_SIGMA_DELTA_EN
      aud_m = (acc_m >= FRAME);
      acc_m = (acc_m % FRAME) + duty_m;
`else
      aud_m = ((t_m % FRAME) < duty_m);
`endif
      if ((t_m % FRAME) == FRAME - 1) duty_m = sum_m;
      sum_m = new_sum;
      t_m++;
    end
    fs_m = (t_m > 0) && ((t_m % FRAME) == 0);
    ce_m = (t_m > 0) && ((t_m % DIV) == 0);
    @(negedge clk);
    check_output("aud_pwm", 32'(bus.AUD_PWM), 32'(aud_m));
    check_output("duty", 32'(bus.duty), 32'(duty_m));
    check_output("frame_start", 32'(bus.frame_start), 32'(fs_m));
    check_output("psg_ce", 32'(bus.psg_ce), 32'(ce_m));
    if (count_ce && t_m >= 1 && t_m <= 2600 && bus.psg_ce === 1'b1) begin
      ce_count++;
      if (first_ce < 0) first_ce = t_m;
    end
    if (t_m > 0 && bus.AUD_PWM === 1'b1) hi_cnt++;
    if ((t_m % FRAME) == 0) begin
`ifndef AUDIO_SIGMA_DELTA_EN
      if (t_m > 0 && frame_valid) check_output("frame_high_count", 32'(hi_cnt), 32'(frame_duty));
`endif
      frame_duty  = duty_m;
      hi_cnt      = 0;
      frame_valid = 1'b1;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int pos);
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (((t_m % FRAME) != pos) && guard < 2 * FRAME);
    check_output("run_until_bound", 32'(guard < 2 * FRAME), 32'd1);
  endtask

  initial begin
    apply_stimulus(0, 0, 0, 0, 4'b0000);
    rst_n = 1'b0;
    run_cycles(3);
    check_output("reset_duty", 32'(bus.duty), 32'd0);
    check_output("reset_aud", 32'(bus.AUD_PWM), 32'd0);

    $display("[TB] idle frames with silent channels");
    rst_n    = 1'b1;
    count_ce = 1'b1;
    run_cycles(3 * FRAME);
    count_ce = 1'b0;
    check_output("psg_ce_count", 32'(ce_count), 32'd100);
    check_output("psg_ce_first", 32'(first_ce), 32'd26);

    $display("[TB] four channels at 64");
    apply_stimulus(64, 64, 64, 64, 4'b1111);
    run_until(0);
    check_output("duty_256", 32'(bus.duty), 32'd256);
    run_until(0);

    $display("[TB] single channel, then enable change mid-frame");
    apply_stimulus(255, 255, 255, 255, 4'b0001);
    run_until(0);
    run_until(512);
    check_output("duty_255", 32'(bus.duty), 32'd255);
    enables = 4'b1111;
    run_until(0);
    check_output("duty_1020", 32'(bus.duty), 32'd1020);
    run_until(0);

    $display("[TB] reset pulse in the middle of a 512 frame");
    apply_stimulus(128, 128, 128, 128, 4'b1111);
    run_until(0);
    run_until(300);
    check_output("duty_512", 32'(bus.duty), 32'd512);
    rst_n = 1'b0;
    step();
    check_output("midreset_duty", 32'(bus.duty), 32'd0);
    check_output("midreset_aud", 32'(bus.AUD_PWM), 32'd0);
    check_output("midreset_psg_ce", 32'(bus.psg_ce), 32'd0);
    check_output("midreset_frame_start", 32'(bus.frame_start), 32'd0);
    rst_n = 1'b1;
    run_cycles(FRAME - 1);
    check_output("post_reset_duty0", 32'(bus.duty), 32'd0);
    step();
    check_output("post_reset_duty512", 32'(bus.duty), 32'd512);
    run_until(0);

    $display("[TB] random samples and enables");
    for (int f = 0; f < 4 * FRAME; f++) begin
      apply_stimulus($urandom_range(255), $urandom_range(255), $urandom_range(255),
                     $urandom_range(255), 4'($urandom_range(15)));
      step();
    end
    apply_stimulus(0, 0, 0, 0, 4'b0000);
    run_until(0);
    run_until(0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
